// File: rtl/decodificador_comandos.sv
// ---------------------------------------------------------------------------
// decodificador_comandos
//
// Command decoder between the UART receiver and the sensor / UART transmitter
// blocks. Each received 16-bit word is {comando, endereco}. The word is
// validated, one request is issued to the sensor block, and the block waits
// for an answer or a timeout. It then builds a 16-bit response word and hands
// it to the UART transmitter. Only one transaction is in flight at a time.
// Words that arrive while a transaction is in progress are dropped and counted.
//
// Ports
//   clock               in   1   system clock, all logic on posedge
//   reset               in   1   asynchronous active-low reset
//   bitsEstaoRecebidos  in   1   one-cycle pulse: byteCompleto valid
//   byteCompleto        in   16  received word {comando, endereco}
//   requisicaoSensor    out  1   level request to the sensor block
//   comandoSensor       out  8   latched command
//   enderecoSensor      out  8   latched address
//   respostaPronta      in   1   one-cycle pulse: sensor answer valid
//   dadosSensor         in   8   sensor data, valid with respostaPronta
//   erroSensor          in   1   sensor failure flag, valid with respostaPronta
//   iniciarTx           out  1   one-cycle start pulse to the UART TX
//   palavraTx           out  16  response word
//   txOcupado           in   1   UART TX busy
//   ocupado             out  1   high whenever the FSM is not in ESPERA
//   descartes           out  8   dropped-word count, saturating at 8'hFF
// ---------------------------------------------------------------------------
module decodificador_comandos #(
    parameter int         NUM_SENSORES   = 32,
    parameter logic [7:0] COMANDO_MAX    = 8'h07,
    parameter int         TIMEOUT_CICLOS = 2_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bitsEstaoRecebidos,
    input  logic [15:0] byteCompleto,
    output logic        requisicaoSensor,
    output logic [7:0]  comandoSensor,
    output logic [7:0]  enderecoSensor,
    input  logic        respostaPronta,
    input  logic [7:0]  dadosSensor,
    input  logic        erroSensor,
    output logic        iniciarTx,
    output logic [15:0] palavraTx,
    input  logic        txOcupado,
    output logic        ocupado,
    output logic [7:0]  descartes
);

    localparam int            TW          = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TW-1:0] TIMER_CARGA = TW'(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] TIMER_UM    = TW'(32'd1);
    localparam logic [TW-1:0] TIMER_ZERO  = TW'(32'd0);
    // Nine bits so that NUM_SENSORES = 256 still compares correctly.
    localparam logic [8:0]    LIMITE_END  = 9'(NUM_SENSORES);

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        VALIDA     = 3'd1,
        REQUISITA  = 3'd2,
        AGUARDA_TX = 3'd3,
        ENVIA      = 3'd4
    } estado_t;

    estado_t        estado_r,    estado_s;
    logic [7:0]     comando_r,   comando_s;
    logic [7:0]     endereco_r,  endereco_s;
    logic           req_r,       req_s;
    logic [15:0]    palavra_r,   palavra_s;
    logic           inicia_r,    inicia_s;
    logic [TW-1:0]  timer_r,     timer_s;
    logic [7:0]     descartes_r, descartes_s;
    logic           ocupado_r,   ocupado_s;

    // Next-state and next-register computation for the whole decoder.
    always_comb begin
        estado_s    = estado_r;
        comando_s   = comando_r;
        endereco_s  = endereco_r;
        req_s       = req_r;
        palavra_s   = palavra_r;
        inicia_s    = 1'b0;
        timer_s     = timer_r;
        descartes_s = descartes_r;

        // Any word arriving outside ESPERA is dropped, including the cycle in
        // which the FSM is about to return to ESPERA.
        if (bitsEstaoRecebidos && (estado_r != ESPERA)) begin
            if (descartes_r != 8'hFF) begin
                descartes_s = descartes_r + 8'd1;
            end else begin
                descartes_s = descartes_r;
            end
        end else begin
            descartes_s = descartes_r;
        end

        case (estado_r)
            ESPERA: begin
                if (bitsEstaoRecebidos) begin
                    comando_s  = byteCompleto[15:8];
                    endereco_s = byteCompleto[7:0];
                    estado_s   = VALIDA;
                end else begin
                    estado_s   = ESPERA;
                end
            end

            VALIDA: begin
                if ((comando_r == 8'h00) || (comando_r > COMANDO_MAX)) begin
                    palavra_s = {8'hE0, 8'h00};
                    estado_s  = AGUARDA_TX;
                end else if ({1'b0, endereco_r} >= LIMITE_END) begin
                    palavra_s = {8'hE1, endereco_r};
                    estado_s  = AGUARDA_TX;
                end else begin
                    req_s     = 1'b1;
                    timer_s   = TIMER_CARGA;
                    estado_s  = REQUISITA;
                end
            end

            REQUISITA: begin
                if (timer_r != TIMER_ZERO) begin
                    timer_s = timer_r - TIMER_UM;
                end else begin
                    timer_s = timer_r;
                end
                // The answer has priority over a timeout in the same cycle.
                // timer_r == 1 marks the last of TIMEOUT_CICLOS cycles here.
                if (respostaPronta) begin
                    req_s    = 1'b0;
                    if (erroSensor) begin
                        palavra_s = {8'hE2, endereco_r};
                    end else begin
                        palavra_s = {comando_r, dadosSensor};
                    end
                    estado_s = AGUARDA_TX;
                end else if (timer_r <= TIMER_UM) begin
                    req_s     = 1'b0;
                    palavra_s = {8'hE3, endereco_r};
                    estado_s  = AGUARDA_TX;
                end else begin
                    estado_s  = REQUISITA;
                end
            end

            AGUARDA_TX: begin
                if (!txOcupado) begin
                    inicia_s = 1'b1;
                    estado_s = ENVIA;
                end else begin
                    estado_s = AGUARDA_TX;
                end
            end

            ENVIA: begin
                // TX raising busy is taken as acceptance of the word.
                if (txOcupado) begin
                    estado_s = ESPERA;
                end else begin
                    estado_s = ENVIA;
                end
            end

            default: begin
                estado_s = ESPERA;
                req_s    = 1'b0;
            end
        endcase

        ocupado_s = (estado_s != ESPERA);
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r    <= ESPERA;
            comando_r   <= 8'h00;
            endereco_r  <= 8'h00;
            req_r       <= 1'b0;
            palavra_r   <= 16'h0000;
            inicia_r    <= 1'b0;
            timer_r     <= TIMER_ZERO;
            descartes_r <= 8'h00;
            ocupado_r   <= 1'b0;
        end else begin
            estado_r    <= estado_s;
            comando_r   <= comando_s;
            endereco_r  <= endereco_s;
            req_r       <= req_s;
            palavra_r   <= palavra_s;
            inicia_r    <= inicia_s;
            timer_r     <= timer_s;
            descartes_r <= descartes_s;
            ocupado_r   <= ocupado_s;
        end
    end

    assign requisicaoSensor = req_r;
    assign comandoSensor    = comando_r;
    assign enderecoSensor   = endereco_r;
    assign iniciarTx        = inicia_r;
    assign palavraTx        = palavra_r;
    assign ocupado          = ocupado_r;
    assign descartes        = descartes_r;

endmodule

// File: tb/tb_decodificador_comandos.sv
// ---------------------------------------------------------------------------
// tb_decodificador_comandos
//
// Scoreboard bench for decodificador_comandos. Every issued word pushes the
// expected response (from a rule-level reference function) into a queue; an
// independent monitor pops and compares whenever iniciarTx is seen. A small
// UART TX model answers iniciarTx with a busy window. The instance uses a
// 50-cycle timeout so timeout behaviour is reachable in short runs.
// ---------------------------------------------------------------------------
module tb_decodificador_comandos;

    localparam int         NUM_S  = 32;
    localparam logic [7:0] CMDMAX = 8'h07;
    localparam int         T      = 50;

    logic        clock;
    logic        reset;
    logic        bitsEstaoRecebidos;
    logic [15:0] byteCompleto;
    logic        requisicaoSensor;
    logic [7:0]  comandoSensor;
    logic [7:0]  enderecoSensor;
    logic        respostaPronta;
    logic [7:0]  dadosSensor;
    logic        erroSensor;
    logic        iniciarTx;
    logic [15:0] palavraTx;
    logic        txOcupado;
    logic        ocupado;
    logic [7:0]  descartes;

    logic        tx_busy;
    logic        tx_hold;
    int          tx_lat_fix;
    int          tx_lat;
    int          tx_count;
    int          checks;
    int          errors;
    int          exp_desc;
    logic [15:0] exp_q[$];
    logic [15:0] w_exp;

    logic [7:0]  cmd, addr;
    int          r, kans, ans, extra, txb, n;
    bit          saw;

    assign txOcupado = tx_busy | tx_hold;

    decodificador_comandos #(
        .NUM_SENSORES  (NUM_S),
        .COMANDO_MAX   (CMDMAX),
        .TIMEOUT_CICLOS(T)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .bitsEstaoRecebidos(bitsEstaoRecebidos),
        .byteCompleto      (byteCompleto),
        .requisicaoSensor  (requisicaoSensor),
        .comandoSensor     (comandoSensor),
        .enderecoSensor    (enderecoSensor),
        .respostaPronta    (respostaPronta),
        .dadosSensor       (dadosSensor),
        .erroSensor        (erroSensor),
        .iniciarTx         (iniciarTx),
        .palavraTx         (palavraTx),
        .txOcupado         (txOcupado),
        .ocupado           (ocupado),
        .descartes         (descartes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Response word from the rules: bad command, bad address, no answer,
    // sensor error, otherwise the data.
    function automatic logic [15:0] ref_resp(input logic [7:0] c, input logic [7:0] a,
                                             input bit answered, input logic [7:0] d,
                                             input logic e);
        if (c == 8'h00 || c > CMDMAX) return 16'hE000;
        if (int'(a) >= NUM_S)         return {8'hE1, a};
        if (!answered)                return {8'hE3, a};
        if (e)                        return {8'hE2, a};
        return {c, d};
    endfunction

    // UART TX model: after iniciarTx, busy rises after a latency, then drops.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (iniciarTx) begin
                tx_lat = (tx_lat_fix >= 0) ? tx_lat_fix : int'($urandom_range(0, 3));
                repeat (tx_lat) @(negedge clock);
                tx_busy = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clock);
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor: every start pulse must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && iniciarTx) begin
                tx_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_iniciarTx", {16'h0000, palavraTx}, 32'hFFFF_FFFF);
                end else begin
                    w_exp = exp_q.pop_front();
                    chk("palavraTx", {16'h0000, palavraTx}, {16'h0000, w_exp});
                end
            end
        end
    end

    // Issue one word starting at a negedge with the DUT idle. kans = negedge
    // index (1 = first negedge with req high) at which the answer is driven,
    // 0 = never. extra_k = negedge at which an extra word is injected.
    task automatic run_req(input logic [7:0] c, input logic [7:0] a, input int ka,
                           input logic [7:0] d, input logic e, input int extra_k);
        bit valid, answered;
        int req_cycles;
        valid    = (c != 8'h00) && (c <= CMDMAX) && (int'(a) < NUM_S);
        answered = valid && (ka >= 1) && (ka <= T);
        exp_q.push_back(ref_resp(c, a, answered, d, e));
        bitsEstaoRecebidos = 1'b1;
        byteCompleto       = {c, a};
        @(negedge clock);
        bitsEstaoRecebidos = 1'b0;
        byteCompleto       = 16'($urandom);
        chk("ocupado_after_word", ocupado, 1);
        chk("req_low_one_edge", requisicaoSensor, 0);
        @(negedge clock);
        chk("req_two_edges", requisicaoSensor, valid);
        if (valid) begin
            chk("comandoSensor", comandoSensor, c);
            chk("enderecoSensor", enderecoSensor, a);
            req_cycles = 0;
            for (int k = 1; k <= T + 2; k++) begin
                if (requisicaoSensor) req_cycles++;
                if (k == ka) begin
                    respostaPronta = 1'b1;
                    dadosSensor    = d;
                    erroSensor     = e;
                end
                if (k == extra_k) begin
                    bitsEstaoRecebidos = 1'b1;
                    byteCompleto       = 16'($urandom);
                    exp_desc           = sat_inc(exp_desc);
                end
                @(negedge clock);
                respostaPronta     = 1'b0;
                bitsEstaoRecebidos = 1'b0;
                dadosSensor        = 8'($urandom);
                erroSensor         = 1'($urandom);
            end
            chk("req_high_cycles", req_cycles, answered ? ka : T);
        end
    endtask

    task automatic finish_txn(input int tx_before, input bit no_req);
        int  m;
        bit  seen;
        m    = 0;
        seen = 1'b0;
        while (ocupado && (m < 3000)) begin
            seen = seen | requisicaoSensor;
            @(negedge clock);
            m++;
        end
        chk("idle_within_budget", (m < 3000), 1);
        if (no_req) chk("req_never_rises", seen, 0);
        chk("one_iniciarTx", tx_count - tx_before, 1);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("descartes", descartes, exp_desc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; tx_count = 0; exp_desc = 0;
        tx_hold = 1'b0; tx_lat_fix = -1;
        reset = 1'b0;
        bitsEstaoRecebidos = 1'b0; byteCompleto = 16'h0000;
        respostaPronta = 1'b0; dadosSensor = 8'h00; erroSensor = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_req", requisicaoSensor, 0);
        chk("rst_comando", comandoSensor, 0);
        chk("rst_endereco", enderecoSensor, 0);
        chk("rst_iniciarTx", iniciarTx, 0);
        chk("rst_palavraTx", palavraTx, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_descartes", descartes, 0);
        reset = 1'b1;
        @(negedge clock);

        // Data response (answer within the 50-cycle window)
        txb = tx_count; run_req(8'h01, 8'h03, 40, 8'h19, 1'b0, 0); finish_txn(txb, 1'b0);
        // Invalid command, zero command, boundary command
        txb = tx_count; run_req(8'h09, 8'h00, 0, 8'h00, 1'b0, 0);  finish_txn(txb, 1'b1);
        txb = tx_count; run_req(8'h00, 8'h05, 0, 8'h00, 1'b0, 0);  finish_txn(txb, 1'b1);
        txb = tx_count; run_req(8'h08, 8'h05, 0, 8'h00, 1'b0, 0);  finish_txn(txb, 1'b1);
        txb = tx_count; run_req(8'h07, 8'h1F, 3, 8'hC3, 1'b0, 0);  finish_txn(txb, 1'b0);
        // Address out of range, boundary address, sensor error
        txb = tx_count; run_req(8'h01, 8'h40, 0, 8'h00, 1'b0, 0);  finish_txn(txb, 1'b1);
        txb = tx_count; run_req(8'h01, 8'h20, 0, 8'h00, 1'b0, 0);  finish_txn(txb, 1'b1);
        txb = tx_count; run_req(8'h01, 8'h05, 10, 8'hAA, 1'b1, 0); finish_txn(txb, 1'b0);
        // Timeout, and answer on the timeout cycle
        txb = tx_count; run_req(8'h02, 8'h05, 0, 8'h00, 1'b0, 0);  finish_txn(txb, 1'b0);
        txb = tx_count; run_req(8'h02, 8'h05, T, 8'h5A, 1'b0, 0);  finish_txn(txb, 1'b0);
        // Answer one cycle too late is ignored
        txb = tx_count; run_req(8'h04, 8'h06, T + 1, 8'h33, 1'b0, 0); finish_txn(txb, 1'b0);

        // Reset in the middle of REQUISITA
        txb = tx_count;
        bitsEstaoRecebidos = 1'b1; byteCompleto = 16'h0205;
        @(negedge clock);
        bitsEstaoRecebidos = 1'b0;
        repeat (10) @(negedge clock);
        bitsEstaoRecebidos = 1'b1;
        @(negedge clock);
        bitsEstaoRecebidos = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_req", requisicaoSensor, 0);
        chk("midrst_iniciarTx", iniciarTx, 0);
        chk("midrst_ocupado", ocupado, 0);
        chk("midrst_descartes", descartes, 0);
        exp_q.delete();
        exp_desc = 0;
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            saw = saw | requisicaoSensor | ocupado;
        end
        chk("post_rst_quiet", saw, 0);
        chk("post_rst_no_tx", tx_count - txb, 0);

        // TX held busy: start deferred; drops counted and saturated
        txb = tx_count;
        tx_hold = 1'b1;
        run_req(8'h03, 8'h1F, 20, 8'h77, 1'b0, 7);
        chk("descartes_single_drop", descartes, 1);
        for (int i = 0; i < 300; i++) begin
            bitsEstaoRecebidos = 1'b1;
            byteCompleto       = 16'($urandom);
            exp_desc           = sat_inc(exp_desc);
            @(negedge clock);
        end
        bitsEstaoRecebidos = 1'b0;
        chk("iniciarTx_held_off", tx_count - txb, 0);
        chk("descartes_saturated", descartes, 8'hFF);
        chk("ocupado_while_held", ocupado, 1);
        tx_hold = 1'b0;
        finish_txn(txb, 1'b0);

        // Word pulse on the cycle of return to ESPERA is dropped
        tx_lat_fix = 2;
        txb = tx_count;
        run_req(8'h00, 8'h11, 0, 8'h00, 1'b0, 0);
        n = 0;
        while (!iniciarTx && (n < 50)) begin
            @(negedge clock);
            n++;
        end
        chk("start_seen", (n < 50), 1);
        @(negedge clock); @(negedge clock);
        bitsEstaoRecebidos = 1'b1; byteCompleto = 16'h0103;
        exp_desc = sat_inc(exp_desc);
        @(negedge clock);
        bitsEstaoRecebidos = 1'b0;
        chk("return_ocupado", ocupado, 0);
        repeat (5) @(negedge clock);
        chk("return_word_dropped", ocupado, 0);
        chk("return_descartes", descartes, exp_desc);
        chk("return_one_tx", tx_count - txb, 1);
        tx_lat_fix = -1;
        repeat (8) @(negedge clock);

        // Randomized transactions against the reference function
        for (int t = 0; t < 40; t++) begin
            r    = int'($urandom_range(0, 9));
            cmd  = (r == 0) ? 8'h00 : (r == 1) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(1, 7));
            r    = int'($urandom_range(0, 9));
            addr = (r < 2) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            r    = int'($urandom_range(0, 9));
            kans = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(T + 1, T + 2)) :
                   (r == 2) ? T : int'($urandom_range(1, T - 1));
            ans  = (kans >= 1 && kans <= T) ? kans : T;
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ans)) : 0;
            txb  = tx_count;
            run_req(cmd, addr, kans, 8'($urandom), 1'($urandom), extra);
            finish_txn(txb, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
